// File: rtl/tag_comparator.sv
// Tag comparator: pops a request from the tag FIFO and collects the 2-beat tag metadata from the R channel.
// It then compares the stored tag against the request tag and emits one registered hit/miss result per request.
module tag_comparator #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 32,
  parameter int ID_WIDTH     = 16,
  parameter int TID_WIDTH    = 16,
  parameter int INDEX_WIDTH  = 10,
  parameter int OFFSET_WIDTH = 6,
  parameter int TAG_WIDTH    = 48,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              tag_fifo_empty_i,
  output logic                              tag_fifo_rden_o,
  input  logic [ADDR_WIDTH+TID_WIDTH:0]     tag_fifo_data_i,
  input  logic [ID_WIDTH-1:0]               rid_i,
  input  logic [DATA_WIDTH-1:0]             rdata_i,
  input  logic                              rlast_i,
  input  logic                              rvalid_i,
  output logic                              rready_o,
  output logic                              res_valid_o,
  input  logic                              res_ready_i,
  output logic                              res_rw_o,
  output logic [TID_WIDTH-1:0]              res_tid_o,
  output logic [ID_WIDTH-1:0]               res_id_o,
  output logic [ADDR_WIDTH-1:0]             res_addr_o,
  output logic                              res_hit_o,
  output logic                              res_dirty_o,
  output logic [ADDR_WIDTH-1:0]             res_victim_addr_o,
  output logic [CNT_WIDTH-1:0]              hit_cnt_o,
  output logic [CNT_WIDTH-1:0]              miss_cnt_o,
  output logic                              protocol_err_o
);

  typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_BEAT1, S_CMP, S_OUT} state_t;

  state_t state, state_nxt;

  logic                   req_rw;
  logic [TID_WIDTH-1:0]   req_tid;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [DATA_WIDTH-1:0]  beat_lo;
  logic [DATA_WIDTH-1:0]  beat_hi;
  logic [ID_WIDTH-1:0]    id_q;

  logic [TAG_WIDTH-1:0]   stored_tag;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] req_index;
  logic                   line_valid;
  logic                   line_dirty;
  logic                   cmp_hit;
  logic                   unused_meta;

  // beat1 carries {valid, dirty, reserved, stored_tag high bits}
  assign stored_tag  = {beat_hi[TAG_WIDTH-DATA_WIDTH-1:0], beat_lo};
  assign req_tag     = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_index   = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign line_valid  = beat_hi[DATA_WIDTH-1];
  assign line_dirty  = line_valid & beat_hi[DATA_WIDTH-2];
  assign cmp_hit     = line_valid && (stored_tag == req_tag);
  assign unused_meta = ^beat_hi[DATA_WIDTH-3:TAG_WIDTH-DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Pop is gated by rst_n so the FIFO is never drained while held in reset
  always_comb begin
    state_nxt       = state;
    tag_fifo_rden_o = 1'b0;
    rready_o        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!tag_fifo_empty_i && rst_n) begin
          tag_fifo_rden_o = 1'b1;
          state_nxt       = S_BEAT0;
        end
      end
      S_BEAT0: begin
        rready_o = 1'b1;
        if (rvalid_i) state_nxt = rlast_i ? S_CMP : S_BEAT1;
      end
      S_BEAT1: begin
        rready_o = 1'b1;
        if (rvalid_i) state_nxt = S_CMP;
      end
      S_CMP:   state_nxt = S_OUT;
      S_OUT:   if (res_ready_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_rw            <= 1'b0;
      req_tid           <= '0;
      req_addr          <= '0;
      beat_lo           <= '0;
      beat_hi           <= '0;
      id_q              <= '0;
      res_valid_o       <= 1'b0;
      res_rw_o          <= 1'b0;
      res_tid_o         <= '0;
      res_id_o          <= '0;
      res_addr_o        <= '0;
      res_hit_o         <= 1'b0;
      res_dirty_o       <= 1'b0;
      res_victim_addr_o <= '0;
      hit_cnt_o         <= '0;
      miss_cnt_o        <= '0;
      protocol_err_o    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tag_fifo_rden_o) {req_rw, req_tid, req_addr} <= tag_fifo_data_i;
        end
        S_BEAT0: begin
          if (rvalid_i) begin
            beat_lo <= rdata_i;
            id_q    <= rid_i;
            // A single-beat response leaves no metadata word, so treat the line as invalid
            if (rlast_i) begin
              beat_hi        <= '0;
              protocol_err_o <= 1'b1;
            end
          end
        end
        S_BEAT1: begin
          if (rvalid_i) begin
            beat_hi <= rdata_i;
            if (!rlast_i) protocol_err_o <= 1'b1;
          end
        end
        S_CMP: begin
          res_valid_o       <= 1'b1;
          res_rw_o          <= req_rw;
          res_tid_o         <= req_tid;
          res_id_o          <= id_q;
          res_addr_o        <= req_addr;
          res_hit_o         <= cmp_hit;
          res_dirty_o       <= line_dirty;
          res_victim_addr_o <= {stored_tag, req_index, {OFFSET_WIDTH{1'b0}}};
          if (cmp_hit) begin
            if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + CNT_WIDTH'(1);
          end else begin
            if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + CNT_WIDTH'(1);
          end
        end
        S_OUT: begin
          if (res_ready_i) res_valid_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
